// File: rtl/operand_loader_if.sv
// Byte stream from the upstream producer into operand_loader.
// The producer drives valid/data/mode; the loader answers with ready.
interface operand_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_mode;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    output in_ready
  );
endinterface

// File: rtl/operand_loader.sv
// Gathers four operand bytes plus a mode bit, kicks the add/subtract control
// FSM with a multi-cycle start, waits for done (or a timeout), then clears it.
module operand_loader #(
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                clock,
  input  logic                reset,
  operand_loader_if.slave     in_if,
  output logic [7:0]          A,
  output logic [7:0]          B,
  output logic [7:0]          C,
  output logic [7:0]          D,
  output logic                mode,
  output logic                start,
  input  logic                done,
  output logic                ctl_reset,
  output logic                op_done,
  output logic                err
);

  localparam int SCW = (START_CYCLES < 2) ? 1 : $clog2(START_CYCLES + 1);
  localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_START   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_CLEAR   = 2'd3;

  logic [1:0]     state;
  logic [1:0]     byte_cnt;
  logic [SCW-1:0] start_cnt;
  logic [WCW-1:0] wait_cnt;
  logic           accept;
  logic           wait_expired;

  assign in_if.in_ready = (state == S_COLLECT) && !reset;
  assign ctl_reset      = reset || (state == S_CLEAR);
  assign accept         = in_if.in_valid && in_if.in_ready;
  // Expiry is judged on the value the counter would take this cycle, so CLEAR lands on w+TIMEOUT.
  assign wait_expired   = (wait_cnt == WCW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_COLLECT;
      byte_cnt  <= 2'd0;
      start_cnt <= '0;
      wait_cnt  <= '0;
      A         <= 8'h00;
      B         <= 8'h00;
      C         <= 8'h00;
      D         <= 8'h00;
      mode      <= 1'b0;
      start     <= 1'b0;
      op_done   <= 1'b0;
      err       <= 1'b0;
    end else begin
      op_done <= 1'b0;
      case (state)
        S_COLLECT: begin
          if (accept) begin
            case (byte_cnt)
              2'd0: begin
                A    <= in_if.in_data;
                mode <= in_if.in_mode;
              end
              2'd1:    B <= in_if.in_data;
              2'd2:    C <= in_if.in_data;
              default: D <= in_if.in_data;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state     <= S_START;
              start     <= 1'b1;
              start_cnt <= SCW'(START_CYCLES);
            end
          end
        end

        S_START: begin
          if (start_cnt == SCW'(1)) begin
            start    <= 1'b0;
            wait_cnt <= '0;
            state    <= S_WAIT;
          end else begin
            start_cnt <= start_cnt - SCW'(1);
          end
        end

        S_WAIT: begin
          // done takes priority over a timeout that expires in the same cycle.
          if (done) begin
            op_done <= 1'b1;
            state   <= S_CLEAR;
          end else if (wait_expired) begin
            err   <= 1'b1;
            state <= S_CLEAR;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end

        S_CLEAR: begin
          state <= S_COLLECT;
        end

        default: begin
          state <= S_COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Table-driven and randomized checks of operand_loader against a job-level
// model: four bytes in, one start burst, then done/timeout and a clear pulse.
module tb_operand_loader;

  localparam int SC = 2;
  localparam int TO = 64;
  localparam int NEVER = 9999;

  logic       clock;
  logic       reset;
  logic [7:0] A, B, C, D;
  logic       mode, start, done, ctl_reset, op_done, err;

  operand_loader_if bus ();

  operand_loader #(.START_CYCLES(SC), .TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_if     (bus),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .mode      (mode),
    .start     (start),
    .done      (done),
    .ctl_reset (ctl_reset),
    .op_done   (op_done),
    .err       (err)
  );

  typedef struct {
    logic [7:0] bytes [4];
    logic       m;
    int         gap;
    int         done_delay;
    bit         early;
    bit         hold;
    logic [7:0] exp_op [4];
    logic       exp_mode;
    bit         exp_op_done;
    bit         exp_err;
  } vec_t;

  int tests = 0;
  int fails = 0;
  bit err_model = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic m);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_mode  = m;
    while (!bus.in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("ready_wait", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    done = 1'b0;
    step();
    reset = 1'b0;
    #1;
    err_model = 1'b0;
  endtask

  // Job-level reference: bytes land in order, mode comes with the first byte,
  // the job ends normally iff done arrives within TIMEOUT wait cycles.
  function automatic vec_t model(input logic [7:0] b0, b1, b2, b3, input logic m,
                                 input int gap, input int dd, input bit early,
                                 input bit hold, input bit err_before);
    vec_t v;
    v.bytes[0] = b0; v.bytes[1] = b1; v.bytes[2] = b2; v.bytes[3] = b3;
    v.m = m; v.gap = gap; v.done_delay = dd; v.early = early; v.hold = hold;
    for (int i = 0; i < 4; i++) v.exp_op[i] = v.bytes[i];
    v.exp_mode    = m;
    v.exp_op_done = (dd < TO);
    v.exp_err     = err_before || (dd >= TO);
    return v;
  endfunction

  task automatic check_ops(input string tag, input vec_t v);
    check({tag, "_A"}, 32'(A), 32'(v.exp_op[0]));
    check({tag, "_B"}, 32'(B), 32'(v.exp_op[1]));
    check({tag, "_C"}, 32'(C), 32'(v.exp_op[2]));
    check({tag, "_D"}, 32'(D), 32'(v.exp_op[3]));
    check({tag, "_mode"}, 32'(mode), 32'(v.exp_mode));
  endtask

  task automatic applyStimulus(input vec_t v);
    int n;
    bit early_clear;
    for (int i = 0; i < 4; i++) begin
      send_byte(v.bytes[i], v.m);
      if (i < 3) idle(v.gap);
    end
    if (v.hold) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
      bus.in_mode  = 1'b1;
    end
    check_ops("load", v);
    check("start_begin", 32'(start), 32'd1);
    check("busy_ready", 32'(bus.in_ready), 32'd0);

    n = 0;
    while (start && n < 50) begin
      done = v.early;
      step();
      n++;
    end
    done = 1'b0;
    check("start_len", 32'(n), 32'(SC));

    if (v.done_delay < TO) begin
      early_clear = 1'b0;
      for (int k = 0; k < v.done_delay; k++) begin
        if (ctl_reset) early_clear = 1'b1;
        step();
      end
      if (ctl_reset) early_clear = 1'b1;
      check("no_early_clear", 32'(early_clear), 32'd0);
      done = 1'b1;
      step();
      done = 1'b0;
    end else begin
      n = 0;
      while (!ctl_reset && n < TO + 10) begin
        step();
        n++;
      end
      check("timeout_len", 32'(n), 32'(TO));
    end

    check("clear_ctl_reset", 32'(ctl_reset), 32'd1);
    check("clear_op_done", 32'(op_done), 32'(v.exp_op_done));
    check("clear_err", 32'(err), 32'(v.exp_err));
    check("clear_ready", 32'(bus.in_ready), 32'd0);
    check_ops("stable", v);
    step();
    check("after_ready", 32'(bus.in_ready), 32'd1);
    check("after_ctl_reset", 32'(ctl_reset), 32'd0);
    check("after_op_done", 32'(op_done), 32'd0);

    if (v.hold) begin
      step();
      bus.in_valid = 1'b0;
      check("hold_A", 32'(A), 32'h0000_00AA);
      check("hold_mode", 32'(mode), 32'd1);
      check("hold_B", 32'(B), 32'(v.exp_op[1]));
      do_reset();
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_A"}, 32'(A), 32'd0);
    check({tag, "_B"}, 32'(B), 32'd0);
    check({tag, "_C"}, 32'(C), 32'd0);
    check({tag, "_D"}, 32'(D), 32'd0);
    check({tag, "_mode"}, 32'(mode), 32'd0);
    check({tag, "_start"}, 32'(start), 32'd0);
    check({tag, "_op_done"}, 32'(op_done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_ctl_reset"}, 32'(ctl_reset), 32'd0);
  endtask

  initial begin
    vec_t tbl [7];
    vec_t v;
    int   n;

    tbl[0] = model(8'h01, 8'h02, 8'hFF, 8'h02, 1'b0, 0, 3,     1'b0, 1'b0, 1'b0);
    tbl[1] = model(8'hFE, 8'h01, 8'h01, 8'h04, 1'b1, 2, 0,     1'b0, 1'b0, 1'b0);
    tbl[2] = model(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 0, 5,     1'b0, 1'b1, 1'b0);
    tbl[3] = model(8'h5A, 8'hA5, 8'h0F, 8'hF0, 1'b1, 1, 5,     1'b1, 1'b0, 1'b0);
    tbl[4] = model(8'h10, 8'h20, 8'h30, 8'h40, 1'b0, 0, TO-1,  1'b0, 1'b0, 1'b0);
    tbl[5] = model(8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 0, NEVER, 1'b0, 1'b0, 1'b0);
    tbl[6] = model(8'h81, 8'h82, 8'h83, 8'h84, 1'b1, 1, 2,     1'b0, 1'b0, 1'b1);

    reset = 1'b1;
    done = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_mode  = 1'b0;
    #1;
    check("rst_ctl_reset", 32'(ctl_reset), 32'd1);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    step();
    step();
    reset = 1'b0;
    #1;
    checkOutput("reset");

    for (int i = 0; i < 7; i++) applyStimulus(tbl[i]);

    // Reset in the middle of collecting: partial bytes are discarded.
    do_reset();
    send_byte(8'h01, 1'b1);
    send_byte(8'hFF, 1'b1);
    reset = 1'b1;
    #1;
    check("midcollect_ctl_reset", 32'(ctl_reset), 32'd1);
    check("midcollect_ready", 32'(bus.in_ready), 32'd0);
    step();
    reset = 1'b0;
    #1;
    checkOutput("midcollect");
    applyStimulus(model(8'hFE, 8'h02, 8'hFF, 8'h02, 1'b0, 0, 3, 1'b0, 1'b0, 1'b0));

    // Reset while waiting for done returns everything to reset values.
    for (int i = 0; i < 4; i++) send_byte(8'(8'h30 + i), 1'b1);
    n = 0;
    while (start && n < 50) begin
      step();
      n++;
    end
    step();
    reset = 1'b1;
    #1;
    check("midwait_ctl_reset", 32'(ctl_reset), 32'd1);
    step();
    reset = 1'b0;
    #1;
    checkOutput("midwait");
    err_model = 1'b0;

    for (int j = 0; j < 25; j++) begin
      int dd;
      dd = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, TO - 1));
      v = model(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                1'($urandom), int'($urandom_range(0, 2)), dd,
                ($urandom_range(0, 3) == 0), 1'b0, err_model);
      applyStimulus(v);
      err_model = v.exp_err;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
# operand_loader

Upstream feeder for the multicycle add/subtract pair (control FSM plus addSub datapath). Accepts operand bytes over a valid/ready stream and assembles them into A, B, C, D with an operation mode. Issues the multi-cycle `start` pulse the control FSM expects, then waits for `done`. Pulses the controller's reset between operations so that back-to-back jobs run without host intervention.

## Interface
- `START_CYCLES`, default 2: number of consecutive cycles `start` is held high.
- `TIMEOUT`, default 64: maximum number of WAIT cycles for `done` before the operation is abandoned.
- `clock` input, 1 bit: single clock; all state changes on the rising edge.
- `reset` input, 1 bit: synchronous, active-high; one clock; reset is synchronous and active-high.
- `in_valid` input, 1 bit: upstream byte present.
- `in_data` input, 8 bits: operand byte, in the order A, B, C, D.
- `in_mode` input, 1 bit: operation mode; sampled together with the A byte.
- `in_ready` output, 1 bit: loader can accept a byte.
- `A`, `B`, `C`, `D` output, 8 bits each: registered operands to addSub.
- `mode` output, 1 bit: registered mode to the control FSM.
- `start` output, 1 bit: start request to the control FSM.
- `done` input, 1 bit: completion flag from the control FSM.
- `ctl_reset` output, 1 bit: reset to the control FSM and addSub; equals `reset` OR the internal clear pulse.
- `op_done` output, 1 bit: one-cycle pulse when an operation completes normally.
- `err` output, 1 bit: sticky timeout flag; cleared only by `reset`.

## Operation
- **States:** COLLECT, START, WAIT, CLEAR.
- **Reset values:**
  - State is COLLECT, byte counter is 0.
  - `A`/`B`/`C`/`D` = 8'h00, `mode` = 0.
  - `start` = 0, `op_done` = 0, `err` = 0.
  - `in_ready` = 0 while `reset` is high; `ctl_reset` = 1 while `reset` is high.
- **COLLECT:**
  - `in_ready` = 1.
  - Each cycle with `in_valid` && `in_ready` writes `in_data` into the register selected by the byte counter (0→A, 1→B, 2→C, 3→D) and increments the counter.
  - On counter 0, `in_mode` is also latched into `mode`.
  - Gaps in `in_valid` are allowed; the counter holds across idle cycles.
  - Accepting byte 3 wraps the counter to 0 and moves to START.
- **START:**
  - `start` = 1 for exactly `START_CYCLES` cycles, counted by a down-counter.
  - Then moves to WAIT.
  - `in_ready` = 0.
- **WAIT:**
  - `start` = 0, `in_ready` = 0.
  - The wait counter increments every cycle.
  - If `done` = 1 is sampled, move to CLEAR (normal completion).
  - If the counter reaches `TIMEOUT` without `done`, set `err` and move to CLEAR (timeout).
  - If `done` and timeout occur in the same cycle, `done` wins and `err` is not set.
- **CLEAR:**
  - Lasts one cycle; `ctl_reset` = 1.
  - `op_done` = 1 only if the exit from WAIT was on `done`.
  - Then returns to COLLECT.
- **Ignored inputs:**
  - `done` outside WAIT is ignored.
  - `in_valid` outside COLLECT is ignored: no register update, no counter change, and upstream must hold the byte.
- **Operand stability:** `A`–`D` and `mode` hold their values through START, WAIT and CLEAR. They change only on accepted bytes in COLLECT.
- **Reset mid-operation:** from any state, reset returns the block to COLLECT with counter 0 and all outputs at reset values. `ctl_reset` follows `reset` in the same cycle.

## Timing
- Byte 3 accepted at cycle t:
  - `D` is valid at t+1.
  - `start` is high on cycles t+1 … t+`START_CYCLES`.
- WAIT begins at cycle t+`START_CYCLES`+1.
- `done` sampled at cycle d:
  - `ctl_reset` and `op_done` are high at d+1.
  - `in_ready` = 1 again at d+2.
- Minimum period between two operations: 4 accept cycles + `START_CYCLES` + WAIT duration + 1.
- Timeout: with WAIT starting at cycle w and no `done`:
  - `err` rises at w+`TIMEOUT`.
  - `ctl_reset` is high on that same cycle (CLEAR).
- All outputs are registered except `in_ready` (decoded from state, gated by `reset`) and `ctl_reset` (OR with `reset`).

## Test plan
- **Add job:**
  - Stimulus: bytes 01, 02, FF, 02 with `in_mode` = 0 on consecutive cycles; `done` driven 3 cycles after `start` falls.
  - Required: A=01, B=02, C=FF, D=02, `mode` = 0; `start` high exactly 2 cycles; `ctl_reset` and `op_done` each pulse one cycle; `in_ready` returns at d+2.
- **Gapped input:**
  - Stimulus: bytes FE, 01, 01, 04 with `in_mode` = 1 and 2 idle cycles between bytes.
  - Required: operands FE/01/01/04, `mode` = 1; `start` begins the cycle after the D byte.
- **Backpressure:**
  - Stimulus: hold `in_valid` = 1 with data AA during START and WAIT.
  - Required: `A`–`D` unchanged; AA is accepted as the next A only after CLEAR.
- **Timeout:**
  - Stimulus: complete a load and never assert `done`.
  - Required: `err` = 1 exactly 64 cycles after WAIT entry; one `ctl_reset` pulse; `op_done` stays 0; `err` stays set through a following good job until `reset`.
- **Reset mid-collect:**
  - Stimulus: accept 01, FF, then assert `reset` for 1 cycle; then send FE, 02, FF, 02.
  - Required: `ctl_reset` high during `reset`; the new bytes land in A=FE, B=02, C=FF, D=02 and one `start` pulse issues.
- **Early done:**
  - Stimulus: assert `done` during START.
  - Required: `done` ignored; the block stays in WAIT until `done` is asserted again.
